design_chain: RTL and testbench

DESIGN_CHAIN -- requirements
Module: design_chain

---
 rtl/design_chain_pkg.sv | 14 +
 rtl/design_chain_if.sv | 29 ++
 rtl/design_chain_stage.sv | 48 ++++
 rtl/design_chain.sv | 89 ++++++++
 tb/tb_design_chain.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/design_chain_pkg.sv
// design_chain_pkg: shared constants and helpers for the design_chain register chain.
//   DEFAULT_WIDTH      - default data word width
//   DEFAULT_NUM_STAGES - default number of chained register slices
//   occ_width()        - bit width needed to count 0..stages valid words
package design_chain_pkg;

  localparam int unsigned DEFAULT_WIDTH      = 32;
  localparam int unsigned DEFAULT_NUM_STAGES = 2;

  function automatic int unsigned occ_width(input int unsigned stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/design_chain_if.sv
// design_chain_if: input and output valid/ready streams of design_chain.
//   in_valid/in_data/in_ready    - producer side stream into the chain
//   out_valid/out_data/out_ready - consumer side stream out of the chain
//   modport master - environment side (drives in_*, out_ready)
//   modport slave  - chain side (drives in_ready, out_valid, out_data)
interface design_chain_if
  import design_chain_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/design_chain_stage.sv
// design_chain_stage: one register slice of the chain (data word + valid bit).
//   clk, rst_n        - clock, async active-low reset
//   flush             - synchronously drops the held word
//   up_valid/up_data  - word offered by the previous slice (or the chain input)
//   up_ready_c        - combinational: this slice takes a word this cycle
//   down_valid/data   - registered word held by this slice
//   down_ready        - next slice (or the consumer) takes the held word
module design_chain_stage
  import design_chain_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             up_ready_c,
  output logic             down_valid,
  output logic [WIDTH-1:0] down_data,
  input  logic             down_ready
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  // Accept when empty or when the held word leaves this same cycle; flush blocks intake.
  assign up_ready_c = !flush && (!valid_q || down_ready);

  // Data only loads on a real transfer so a stalled word never changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (up_ready_c) begin
      valid_q <= up_valid;
      if (up_valid) begin
        data_q <= up_data;
      end
    end
  end

  assign down_valid = valid_q;
  assign down_data  = data_q;

endmodule

// File: rtl/design_chain.sv
// design_chain: NUM_STAGES-deep valid/ready register chain with full throughput.
//   clk, rst_n - clock, async active-low reset
//   flush      - drops every held word at the next edge, blocks intake this cycle
//   bus        - design_chain_if.slave: in_valid/in_data/in_ready, out_valid/out_data/out_ready
//   occupancy  - number of valid slices; exists only with DESIGN_CHAIN_OCCUPANCY_EN defined
module design_chain
  import design_chain_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter int unsigned NUM_STAGES = DEFAULT_NUM_STAGES
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 flush,
  design_chain_if.slave                        bus
`ifdef DESIGN_CHAIN_OCCUPANCY_EN
  ,
  output logic [occ_width(NUM_STAGES)-1:0]     occupancy
`endif
);

  logic [NUM_STAGES-1:0]            valid;
  logic [NUM_STAGES-1:0][WIDTH-1:0] data;

  // Slice k feeds slice k+1; ready ripples back from out_ready through per-slice signals.
  for (genvar k = 0; k < int'(NUM_STAGES); k++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;
    logic             down_ready;
    logic             ready;

    if (k == 0) begin : g_first
      assign up_valid = bus.in_valid;
      assign up_data  = bus.in_data;
    end else begin : g_next
      assign up_valid = valid[k-1];
      assign up_data  = data[k-1];
    end

    if (k == int'(NUM_STAGES) - 1) begin : g_last
      assign down_ready = bus.out_ready;
    end else begin : g_mid
      assign down_ready = g_stage[k+1].ready;
    end

    design_chain_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .up_valid   (up_valid),
      .up_data    (up_data),
      .up_ready_c (ready),
      .down_valid (valid[k]),
      .down_data  (data[k]),
      .down_ready (down_ready)
    );
  end

  assign bus.in_ready  = g_stage[0].ready;
  assign bus.out_valid = valid[NUM_STAGES-1];
  assign bus.out_data  = data[NUM_STAGES-1];

`ifdef DESIGN_CHAIN_OCCUPANCY_EN
  localparam int unsigned OCC_W = occ_width(NUM_STAGES);

  logic             push;
  logic             pop;
  logic [OCC_W-1:0] occ_q;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // Internal slice-to-slice moves keep the count; only chain-boundary transfers change it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else if (flush) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_q + OCC_W'(push) - OCC_W'(pop);
    end
  end

  assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_design_chain.sv
// tb_design_chain: directed and randomised checks of design_chain.
//   dut  - WIDTH=32, NUM_STAGES=2 for directed scenarios
//   dut5 - WIDTH=8,  NUM_STAGES=5 for the randomised scoreboard run
//   Occupancy is checked when DESIGN_CHAIN_OCCUPANCY_EN is defined.
module tb_design_chain;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  design_chain_if #(.WIDTH(32)) bus ();
  design_chain_if #(.WIDTH(8))  bus5 ();

`ifdef DESIGN_CHAIN_OCCUPANCY_EN
  logic [1:0] occ;
  logic [2:0] occ5;
`endif

  design_chain #(
    .WIDTH      (32),
    .NUM_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus)
`ifdef DESIGN_CHAIN_OCCUPANCY_EN
    ,
    .occupancy (occ)
`endif
  );

  design_chain #(
    .WIDTH      (8),
    .NUM_STAGES (5)
  ) dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus5)
`ifdef DESIGN_CHAIN_OCCUPANCY_EN
    ,
    .occupancy (occ5)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    bus5.in_valid  = 1'b0;
    bus5.in_data   = '0;
    bus5.out_ready = 1'b0;
    #3;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); else passes++;
    checks++; if (bus.out_data !== 32'h0) $display("FAIL reset_out_data: got %h want 0", bus.out_data); else passes++;
    checks++; if (bus5.out_valid !== 1'b0) $display("FAIL reset_out_valid5: got %0b want 0", bus5.out_valid); else passes++;
`ifdef DESIGN_CHAIN_OCCUPANCY_EN
    checks++; if (occ !== 2'd0) $display("FAIL reset_occupancy: got %0d want 0", occ); else passes++;
`endif
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); else passes++;
  endtask

  task automatic test_latency;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hA5A5_A5A5;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL latency_early: got out_valid %0b want 0", bus.out_valid); else passes++;
    tick();
    checks++; if (bus.out_valid !== 1'b1) $display("FAIL latency_valid: got %0b want 1", bus.out_valid); else passes++;
    checks++; if (bus.out_data !== 32'hA5A5_A5A5) $display("FAIL latency_data: got %h want a5a5a5a5", bus.out_data); else passes++;
    tick();
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL latency_single: got out_valid %0b want 0", bus.out_valid); else passes++;
  endtask

  // Word c is offered before edge c and must be visible right after edge c+1.
  task automatic test_stream;
    bit exp_v;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 102; c++) begin
      bus.in_valid = (c < 100);
      bus.in_data  = 32'(c);
      tick();
      exp_v = (c >= 1) && (c <= 100);
      checks++; if (bus.out_valid !== exp_v) $display("FAIL stream_valid c=%0d: got %0b want %0b", c, bus.out_valid, exp_v); else passes++;
      if (exp_v) begin
        checks++; if (bus.out_data !== 32'(c - 1)) $display("FAIL stream_data c=%0d: got %0d want %0d", c, bus.out_data, c - 1); else passes++;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_backpressure;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h11;
    #1;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL bp_ready0: got %0b want 1", bus.in_ready); else passes++;
    tick();
    bus.in_data = 32'h22;
    #1;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL bp_ready1: got %0b want 1", bus.in_ready); else passes++;
    tick();
    bus.in_data = 32'h33;
    #1;
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL bp_full_ready: got %0b want 0", bus.in_ready); else passes++;
    checks++; if (bus.out_data !== 32'h11) $display("FAIL bp_head: got %h want 11", bus.out_data); else passes++;
`ifdef DESIGN_CHAIN_OCCUPANCY_EN
    checks++; if (occ !== 2'd2) $display("FAIL bp_occ_full: got %0d want 2", occ); else passes++;
`endif
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h11) $display("FAIL bp_stall_stable: got %0b/%h want 1/11", bus.out_valid, bus.out_data); else passes++;
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL bp_pop_push_ready: got %0b want 1", bus.in_ready); else passes++;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_data !== 32'h22) $display("FAIL bp_after_pop: got %h want 22", bus.out_data); else passes++;
`ifdef DESIGN_CHAIN_OCCUPANCY_EN
    checks++; if (occ !== 2'd2) $display("FAIL bp_occ_kept: got %0d want 2", occ); else passes++;
`endif
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h33) $display("FAIL bp_third: got %0b/%h want 1/33", bus.out_valid, bus.out_data); else passes++;
    tick();
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL bp_drained: got %0b want 0", bus.out_valid); else passes++;
  endtask

  task automatic test_flush;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h1;
    tick();
    bus.in_data = 32'h2;
    tick();
    bus.out_ready = 1'b1;
    flush         = 1'b1;
    bus.in_data   = 32'h99;
    #1;
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL flush_in_ready: got %0b want 0", bus.in_ready); else passes++;
    checks++; if (bus.out_valid !== 1'b1) $display("FAIL flush_cur_valid: got %0b want 1", bus.out_valid); else passes++;
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL flush_cleared: got %0b want 0", bus.out_valid); else passes++;
`ifdef DESIGN_CHAIN_OCCUPANCY_EN
    checks++; if (occ !== 2'd0) $display("FAIL flush_occ: got %0d want 0", occ); else passes++;
`endif
    tick();
    tick();
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL flush_no_accept: got %0b want 0", bus.out_valid); else passes++;
  endtask

  task automatic test_reset_mid;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h100;
    tick();
    bus.in_data = 32'h101;
    tick();
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL rstmid_valid: got %0b want 0", bus.out_valid); else passes++;
    checks++; if (bus.out_data !== 32'h0) $display("FAIL rstmid_data: got %h want 0", bus.out_data); else passes++;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h200;
    tick();
    bus.in_data = 32'h201;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL rstmid_no_old: got %0b want 0", bus.out_valid); else passes++;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h200) $display("FAIL rstmid_first: got %0b/%h want 1/200", bus.out_valid, bus.out_data); else passes++;
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h201) $display("FAIL rstmid_second: got %0b/%h want 1/201", bus.out_valid, bus.out_data); else passes++;
    tick();
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL rstmid_end: got %0b want 0", bus.out_valid); else passes++;
  endtask

  // Scoreboard on the 5-deep chain; drains during the final cycles.
  task automatic test_random;
    logic [7:0] q[$];
    logic [7:0] held;
    logic [7:0] word;
    bit         stalled;
    bit         exp_rdy;
    bit         push;
    bit         pop;
    stalled = 1'b0;
    held    = '0;
    for (int c = 0; c < 600; c++) begin
      if (c < 520) begin
        bus5.in_valid  = ($urandom_range(0, 9) < 6);
        bus5.out_ready = ($urandom_range(0, 9) < 5);
      end else begin
        bus5.in_valid  = 1'b0;
        bus5.out_ready = 1'b1;
      end
      bus5.in_data = 8'($urandom);
      #1;
`ifdef DESIGN_CHAIN_OCCUPANCY_EN
      checks++; if (occ5 !== 3'(q.size())) $display("FAIL rnd_occ c=%0d: got %0d want %0d", c, occ5, q.size()); else passes++;
`endif
      exp_rdy = bus5.out_ready || (q.size() < 5);
      checks++; if (bus5.in_ready !== exp_rdy) $display("FAIL rnd_in_ready c=%0d: got %0b want %0b", c, bus5.in_ready, exp_rdy); else passes++;
      if (stalled) begin
        checks++; if (bus5.out_valid !== 1'b1 || bus5.out_data !== held) $display("FAIL rnd_stall c=%0d: got %0b/%h want 1/%h", c, bus5.out_valid, bus5.out_data, held); else passes++;
      end
      pop  = bus5.out_valid && bus5.out_ready;
      push = bus5.in_valid && bus5.in_ready;
      if (pop) begin
        checks++; if (q.size() == 0 || bus5.out_data !== q[0]) $display("FAIL rnd_order c=%0d: got %h want %h (queue %0d)", c, bus5.out_data, (q.size() == 0) ? 8'h0 : q[0], q.size()); else passes++;
      end
      stalled = bus5.out_valid && !bus5.out_ready;
      held    = bus5.out_data;
      word    = bus5.in_data;
      tick();
      if (pop && q.size() != 0) void'(q.pop_front());
      if (push) q.push_back(word);
    end
    checks++; if (q.size() != 0 || bus5.out_valid !== 1'b0) $display("FAIL rnd_drain: got queue %0d valid %0b want 0/0", q.size(), bus5.out_valid); else passes++;
    bus5.in_valid  = 1'b0;
    bus5.out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stream();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached with %0d/%0d passed", passes, checks);
    $fatal(1, "watchdog");
  end

endmodule
